// File: rtl/popcount_scheduler.sv
// popcount_scheduler: round-robin front end for a shared, fixed-latency
// 32-input popcount datapath. It grants one requester word per cycle,
// issues it to the datapath, and tags each word with its requester ID
// through a pipeline matched to the datapath latency. It then routes
// each returning count back to its requester as a one-cycle strobe.
//
// Parameters: NREQ requesters (2..8), LATENCY datapath stages (>=1),
//             ACC_W response width (>=6).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/data/last   per-requester word offers (data 32 bits each)
//   req_ready             one-hot combinational grant
//   pc_valid, pc_data     registered word to the datapath
//   pc_result             datapath count, LATENCY cycles after pc_data
//   rsp_valid, rsp_count  one-hot response strobe and its count
// Optional feature: define POPCNT_SCHED_ACC_EN for per-requester
// saturating packet accumulation (responses only on last words).
module popcount_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 9,
    parameter int ACC_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 pc_valid,
    output logic [31:0]          pc_data,
    input  logic [5:0]           pc_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [ACC_W-1:0]     rsp_count
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win_id;
    logic           win_any;
    logic [31:0]    win_data;

    // First valid index at or after ptr, scanning modulo NREQ.
    always_comb begin
        int idx;
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!win_any && req_valid[IDW'(idx)]) begin
                win_any = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    assign req_ready = win_any ? (NREQ'(1) << win_id) : '0;
    assign win_data  = req_data[32*int'(win_id) +: 32];
    assign ptr_nxt   = (int'(win_id) == NREQ - 1) ? '0
                                                  : win_id + IDW'(1);

    // Stage 0 of the tag pipe is captured alongside pc_valid; stage
    // LATENCY lines up with pc_result.
    logic [LATENCY:0] tag_v;
    logic [IDW-1:0]   tag_id [LATENCY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            pc_valid <= 1'b0;
            pc_data  <= '0;
            tag_v    <= '0;
        end else begin
            pc_valid <= win_any;
            tag_v    <= {tag_v[LATENCY-1:0], win_any};
            if (win_any) begin
                pc_data <= win_data;
                ptr     <= ptr_nxt;
            end
        end
    end

    // Payload needs no reset: it is qualified by tag_v.
    always_ff @(posedge clk) begin
        tag_id[0] <= win_id;
        for (int k = 1; k <= LATENCY; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

    logic           tail_v;
    logic [IDW-1:0] tail_id;

    assign tail_v  = tag_v[LATENCY];
    assign tail_id = tag_id[LATENCY];

`ifdef POPCNT_SCHED_ACC_EN
    logic             tag_last [LATENCY+1];
    logic [ACC_W-1:0] acc [NREQ];
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_sat;

    always_ff @(posedge clk) begin
        tag_last[0] <= req_last[win_id];
        for (int k = 1; k <= LATENCY; k++) begin
            tag_last[k] <= tag_last[k-1];
        end
    end

    assign sum     = {1'b0, acc[tail_id]} + (ACC_W+1)'(pc_result);
    assign sum_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_count <= '0;
            for (int i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
        end else begin
            rsp_valid <= '0;
            if (tail_v) begin
                if (tag_last[LATENCY]) begin
                    rsp_valid     <= NREQ'(1) << tail_id;
                    rsp_count     <= sum_sat;
                    acc[tail_id]  <= '0;
                end else begin
                    acc[tail_id]  <= sum_sat;
                end
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_count <= '0;
        end else begin
            rsp_valid <= '0;
            if (tail_v) begin
                rsp_valid <= NREQ'(1) << tail_id;
                rsp_count <= ACC_W'(pc_result);
            end
        end
    end
`endif

endmodule

// File: doc/popcount_scheduler.md
# popcount_scheduler

Round-robin scheduler that shares one 32-input popcount datapath among several requesters. It sits in front of the path-balanced, fixed-latency popcount unit. Each cycle it grants at most one requester word, drives that word into the datapath, and tracks the requester ID through a tag pipeline matched to the datapath depth. It then routes each returning count back to the right requester as a one-cycle response.

## Interface
- NREQ, 4, number of requesters (2..8)
- LATENCY, 9, clock stages from pc_data to the matching pc_result (≥1)
- ACC_W, 16, width of rsp_count (≥6)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a word pending
- req_data  in  32*NREQ  word of requester i in bits [32i+31:32i]
- req_last  in  NREQ  word closes a packet (used only with accumulation)
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- pc_valid  out  1  pc_data carries a granted word
- pc_data  out  32  word to popcount datapath
- pc_result  in  6  datapath count, 0..32, valid LATENCY cycles after pc_data
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe
- rsp_count  out  ACC_W  count belonging to the rsp_valid bit

## Operation
- Arbiter:
  - req_ready is combinational from req_valid and the priority pointer ptr.
  - Winner is the first valid index at or after ptr, scanning modulo NREQ.
  - After a handshake, ptr becomes winner+1 mod NREQ; with no handshake, ptr holds.
  - All req_ready bits are 0 when no req_valid bit is set.
  - There is no backpressure from the datapath; one word can issue every cycle.
- Issue register:
  - On handshake, pc_data is loaded with the granted word, pc_valid=1, and the tag (ID, last) is captured.
  - Otherwise pc_valid=0 and pc_data holds its value.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, ID, last}, entered alongside pc_valid.
  - Its tail aligns with pc_result.
  - pc_result is sampled only when the tail is valid; otherwise it is ignored.
- Response:
  - One cycle after a valid tail, rsp_valid[ID]=1 for exactly one cycle.
  - rsp_count = pc_result zero-extended, or the accumulated value (see Configuration).
- Simultaneous events:
  - A new issue and a returning result in the same cycle are independent and both complete.
  - Multiple requesters may have words in flight, interleaved in any order.
- Reset (any cycle, including mid-stream):
  - ptr=0, all tag valids=0, pc_valid=0, pc_data=0, rsp_valid=0, rsp_count=0, accumulators=0.
  - Datapath results still in flight at reset are dropped, because their tags are cleared.

## Timing
- Handshake at edge t → pc_data/pc_valid valid in cycle t+1.
- pc_result valid in cycle t+1+LATENCY.
- rsp_valid asserted in cycle t+2+LATENCY.
- Throughput: one word per cycle aggregate.
- A lone requester holding valid continuously gets one grant every cycle.
- With k requesters continuously valid, each is granted exactly once per k cycles.
- All outputs except req_ready are registered; req_ready is combinational from req_valid and ptr.

## Configuration
- POPCNT_SCHED_ACC_EN defined:
  - Each requester has an ACC_W-bit accumulator, and each returning result is added to it.
  - rsp_valid fires only for results whose tag has last=1. rsp_count = accumulator + pc_result, and that accumulator clears to 0 in the same cycle.
  - The sum saturates at 2^ACC_W−1.
  - Accumulators of different requesters are independent under interleaving.
- POPCNT_SCHED_ACC_EN undefined:
  - No accumulators are built and req_last is ignored.
  - Every result produces a response, with rsp_count = {ACC_W−6 zeros, pc_result}.

## Test plan
- Single requester, NREQ=4, LATENCY=9: one handshake at cycle 10 with word 32'hFFFF_0000 → pc_valid at 11; datapath model returns 16 at 20; rsp_valid=4'b0001, rsp_count=16 at 21.
- All four requesters valid for 8 cycles, ptr=0 → grants 0,1,2,3,0,1,2,3; responses return in the same ID order with the correct counts.
- Word 32'hFFFF_FFFF then 32'h0 back-to-back → rsp_count 32 then 0 on consecutive cycles; no dropped or merged responses.
- rst pulsed while 5 words are in flight → no rsp_valid after reset for those words; ptr=0; the first post-reset grant goes to the lowest valid index.
- ACC_EN defined:
  - Requester 2 sends 3 words (counts 10, 20, 5, last on the third) interleaved with requester 0 single-word packets → one rsp for ID 2 with rsp_count=35, ID 0 responses unaffected.
  - ACC_W=6 with 3×32 → rsp_count saturates at 63.
